// File: rtl/ram_arbiter.sv
// Two-master round-robin arbiter and access sequencer in front of a
// single-port word RAM. Each transaction walks IDLE -> ACCESS -> DONE.
// The RAM side is driven from registers. Read data is registered, and the
// owning master gets a one-cycle ack while the FSM is in DONE.
module ram_arbiter #(
  parameter int unsigned WAIT_CYCLES = 1,
  parameter int unsigned CNT_W       = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [31:0] m0_addr,
  input  logic [3:0]  m0_sel,
  input  logic [31:0] m0_wdata,
  output logic [31:0] m0_rdata,
  output logic        m0_ack,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [31:0] m1_addr,
  input  logic [3:0]  m1_sel,
  input  logic [31:0] m1_wdata,
  output logic [31:0] m1_rdata,
  output logic        m1_ack,
  output logic        ram_ce,
  output logic        ram_we,
  output logic [31:0] ram_addr,
  output logic [3:0]  ram_sel,
  output logic [31:0] ram_wdata,
  input  logic [31:0] ram_rdata,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               last_gnt_q, last_gnt_d;
  logic               owner_q, owner_d;
  logic               ram_ce_q, ram_ce_d;
  logic               ram_we_q, ram_we_d;
  logic [31:0]        ram_addr_q, ram_addr_d;
  logic [3:0]         ram_sel_q, ram_sel_d;
  logic [31:0]        ram_wdata_q, ram_wdata_d;
  logic [31:0]        m0_rdata_q, m0_rdata_d;
  logic [31:0]        m1_rdata_q, m1_rdata_d;
  logic               m0_ack_q, m0_ack_d;
  logic               m1_ack_q, m1_ack_d;
  logic               gnt;

  // State and datapath registers; reset aborts any transaction immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      last_gnt_q  <= 1'b1;
      owner_q     <= 1'b0;
      ram_ce_q    <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_sel_q   <= '0;
      ram_wdata_q <= '0;
      m0_rdata_q  <= '0;
      m1_rdata_q  <= '0;
      m0_ack_q    <= 1'b0;
      m1_ack_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      last_gnt_q  <= last_gnt_d;
      owner_q     <= owner_d;
      ram_ce_q    <= ram_ce_d;
      ram_we_q    <= ram_we_d;
      ram_addr_q  <= ram_addr_d;
      ram_sel_q   <= ram_sel_d;
      ram_wdata_q <= ram_wdata_d;
      m0_rdata_q  <= m0_rdata_d;
      m1_rdata_q  <= m1_rdata_d;
      m0_ack_q    <= m0_ack_d;
      m1_ack_q    <= m1_ack_d;
    end
  end

  // Next-state logic: grant and capture in IDLE, count down in ACCESS,
  // set the ack when leaving ACCESS so that it is high for the DONE cycle.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    last_gnt_d  = last_gnt_q;
    owner_d     = owner_q;
    ram_ce_d    = ram_ce_q;
    ram_we_d    = ram_we_q;
    ram_addr_d  = ram_addr_q;
    ram_sel_d   = ram_sel_q;
    ram_wdata_d = ram_wdata_q;
    m0_rdata_d  = m0_rdata_q;
    m1_rdata_d  = m1_rdata_q;
    m0_ack_d    = 1'b0;
    m1_ack_d    = 1'b0;
    // On a tie, grant the master that was not granted last; otherwise grant
    // whichever master is requesting (1 selects m1).
    gnt         = (m0_req && m1_req) ? ~last_gnt_q : m1_req;
    case (state_q)
      IDLE: begin
        if (m0_req || m1_req) begin
          owner_d     = gnt;
          last_gnt_d  = gnt;
          ram_ce_d    = 1'b1;
          ram_we_d    = gnt ? m1_we    : m0_we;
          ram_addr_d  = gnt ? m1_addr  : m0_addr;
          ram_sel_d   = gnt ? m1_sel   : m0_sel;
          ram_wdata_d = gnt ? m1_wdata : m0_wdata;
          cnt_d       = CNT_W'(WAIT_CYCLES - 1);
          state_d     = ACCESS;
        end
      end
      ACCESS: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          if (!ram_we_q) begin
            if (owner_q) m1_rdata_d = ram_rdata;
            else         m0_rdata_d = ram_rdata;
          end
          if (owner_q) m1_ack_d = 1'b1;
          else         m0_ack_d = 1'b1;
          ram_ce_d = 1'b0;
          ram_we_d = 1'b0;
          state_d  = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign m0_rdata  = m0_rdata_q;
  assign m1_rdata  = m1_rdata_q;
  assign m0_ack    = m0_ack_q;
  assign m1_ack    = m1_ack_q;
  assign ram_ce    = ram_ce_q;
  assign ram_we    = ram_we_q;
  assign ram_addr  = ram_addr_q;
  assign ram_sel   = ram_sel_q;
  assign ram_wdata = ram_wdata_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Two-master arbiter and sequencer in front of the single-port word RAM (ce/we/addr/sel, byte lanes, write on clock edge, combinational read).
- Lets the instruction-fetch master (m1) and the load/store master (m0) share one RAM.
- Uses round-robin grant, a configurable access-wait count, registered RAM-side drive and registered read data with a one-cycle ack pulse per transaction.

Parameters:
- WAIT_CYCLES, 1, cycles ram_ce is held per transaction (legal range 1..15).
- CNT_W, 4, width of the wait counter; must hold WAIT_CYCLES.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- m0_req  in  1  master 0 (data) request, held until m0_ack
- m0_we  in  1  1 = write, 0 = read
- m0_addr  in  32  byte address
- m0_sel  in  4  byte-lane enables, bit n = data[8n+7:8n]
- m0_wdata  in  32  write data
- m0_rdata  out  32  read data, valid when m0_ack=1
- m0_ack  out  1  one-cycle completion pulse
- m1_req, m1_we, m1_addr, m1_sel, m1_wdata, m1_rdata, m1_ack: same as m0_*, for master 1 (instruction fetch)
- ram_ce  out  1  RAM chip enable
- ram_we  out  1  RAM write enable
- ram_addr  out  32  RAM address
- ram_sel  out  4  RAM byte lanes
- ram_wdata  out  32  RAM write data
- ram_rdata  in  32  RAM read data (combinational from RAM)
- busy  out  1  1 whenever state != IDLE

Behaviour:
- Reset (async, immediate):
  - state=IDLE, cnt=0, last_gnt=1, owner=0.
  - All outputs are 0: ram_ce, ram_we, ram_addr, ram_sel, ram_wdata, m0/m1_rdata, m0/m1_ack, busy.
- Reset mid-operation aborts the transaction: ram_ce drops at once, no ack is issued, and a write may be partially applied.
- FSM:
  - IDLE:
    - If any req is high, pick owner, capture that master's we/addr/sel/wdata into ram_* registers, set ram_ce=1, cnt=WAIT_CYCLES-1, and go to ACCESS.
    - If no req is high, stay in IDLE.
  - ACCESS:
    - ram_ce=1; ram_* hold the captured values.
    - If cnt!=0: cnt-=1.
    - If cnt==0:
      - On a read, latch ram_rdata into the owner's rdata.
      - Set ram_ce=0 and ram_we=0; go to DONE.
  - DONE:
    - owner's ack=1 for this one cycle; go to IDLE.
- Grant rule when both req are high in IDLE: grant the master != last_gnt. After reset, m0 wins the first tie.
  - A single requester is always granted.
  - last_gnt := owner on each grant.
- Latency:
  - req high in cycle T while IDLE gives ack in cycle T+WAIT_CYCLES+1.
  - Best-case issue rate is one transaction per WAIT_CYCLES+2 cycles.
- Handshake:
  - A master must hold req and its fields stable until it samples ack=1, then drop req or present a new request on the following cycle.
  - Fields are captured at grant; later changes are ignored until the next grant.
  - req dropping during ACCESS is a protocol violation. The transaction still completes and ack is still pulsed.
- Writes:
  - The RAM commits on every ACCESS edge with ce&we, repeating the same value (idempotent).
  - rdata is unchanged on writes.
- rdata of each master holds its last read value until that master's next read completes.
- ack is never high for both masters in the same cycle. ack is never high in IDLE or ACCESS.
- The non-owner's pending request simply waits; it is never dropped.
- Both req high back-to-back: grants alternate m0, m1, m0, …

Test Plan:
- WAIT_CYCLES=1. Reset, then m0 reads addr 0x0 (RAM word 0 preloaded 0xDEADBEEF) -> ram_ce high exactly 1 cycle; m0_ack at cycle 2 after req with m0_rdata=0xDEADBEEF; m1_ack stays 0.
- m1 writes addr 0x8, sel=4'b0011, wdata=0x12345678, then m1 reads 0x8 (word preloaded 0xAABBCCDD) -> m1_rdata=0xAABB5678.
- m0 and m1 assert req on the same cycle after reset and hold them -> acks come m0 then m1, then alternate m0, m1, m0, m1; each master sees one ack per 2*(WAIT_CYCLES+2) cycles.
- WAIT_CYCLES=3. m0 read -> ram_ce high exactly 3 consecutive cycles; ack 4 cycles after req.
- Assert rst during ACCESS of an m1 read -> same-cycle: ram_ce=0, busy=0, m1_ack never pulses. After release, an m0+m1 tie grants m0 first.
- m0 changes m0_addr from 0x4 to 0x10 during ACCESS -> ram_addr stays 0x4 and the returned data is word 1.
